pipeline_control_unit: RTL and testbench
========================================

PIPELINE_CONTROL_UNIT -- requirements
Module: pipeline_control_unit

Interface
REQ-001 Parameter MEM_TIMEOUT, default 255: maximum consecutive cycles freeze_all stays asserted for one memory request (range 2..1023).
REQ-002 Parameter CNT_W, default 16: width of the performance counters.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 hazard_detected  input  1  RAW hazard flag from the hazard detection unit (ID-stage sources vs EXE/MEM destinations).
REQ-006 branch_taken  input  1  taken branch resolved in EXE.
REQ-007 mem_r_en  input  1  MEM-stage load request.
REQ-008 mem_w_en  input  1  MEM-stage store request.
REQ-009 sram_ready  input  1  SRAM controller completion, valid in the cycle the access finishes.
REQ-010 freeze_if  output  1  hold PC and IF/ID register.
REQ-011 freeze_id  output  1  hold ID stage (paired with freeze_if on a hazard).
REQ-012 bubble_id_exe  output  1  load a NOP (all enables 0) into ID/EXE.
REQ-013 flush_if_id  output  1  clear IF/ID register.
REQ-014 flush_id_exe  output  1  clear ID/EXE register.
REQ-015 freeze_all  output  1  hold every pipeline register and the PC.
REQ-016 mem_error  output  1  sticky memory-timeout flag.
REQ-017 stall_cycles  output  CNT_W  saturating count of stall cycles.
REQ-018 flush_events  output  CNT_W  saturating count of flush cycles.

Function
REQ-019 Two-state FSM: RUN, MEM_WAIT; 10-bit wait counter wait_cnt.
REQ-020 mem_req = mem_r_en | mem_w_en.
REQ-021 Control outputs (REQ-010..REQ-015) are combinational from state, wait_cnt and current inputs, so they are valid in the same cycle.
REQ-022 RUN with mem_req=1 and sram_ready=1: zero-wait access; freeze_all=0; stay in RUN.
REQ-023 RUN with mem_req=1 and sram_ready=0: freeze_all=1; wait_cnt<=1; next state MEM_WAIT.
REQ-024 MEM_WAIT with sram_ready=1: freeze_all=0 in that cycle; wait_cnt<=0; next state RUN.
REQ-025 MEM_WAIT with sram_ready=0 and wait_cnt<MEM_TIMEOUT: freeze_all=1; wait_cnt increments.
REQ-026 MEM_WAIT with sram_ready=0 and wait_cnt==MEM_TIMEOUT (abort cycle): freeze_all=0; mem_error<=1; wait_cnt<=0; next state RUN.
REQ-027 freeze_all is never asserted for more than MEM_TIMEOUT consecutive cycles.
REQ-028 Priority: freeze_all > branch flush > hazard stall.
REQ-029 When freeze_all=1: freeze_if=freeze_id=bubble_id_exe=flush_if_id=flush_id_exe=0; branch_taken and hazard_detected are held stable by the frozen pipeline and are acted on in the first cycle freeze_all=0.
REQ-030 When freeze_all=0 and branch_taken=1: flush_if_id=flush_id_exe=1; hazard_detected is ignored (the dependent instruction is discarded).
REQ-031 When freeze_all=0, branch_taken=0 and hazard_detected=1: freeze_if=freeze_id=bubble_id_exe=1.
REQ-032 stall_cycles increments by 1 in every cycle where freeze_all or bubble_id_exe is 1; it holds at 2^CNT_W-1.
REQ-033 flush_events increments by 1 in every cycle where flush_if_id is 1; it holds at 2^CNT_W-1.
REQ-034 mem_error, once set, stays 1 until rst; it does not alter later sequencing.

Reset
REQ-035 With rst=1 at a clock edge: state<=RUN, wait_cnt<=0, mem_error<=0, stall_cycles<=0, flush_events<=0.
REQ-036 While rst=1, all combinational control outputs are forced to 0.
REQ-037 rst asserted in MEM_WAIT abandons the request; the FSM is in RUN in the cycle after reset deasserts.

Verification
REQ-038 hazard_detected=1 for 2 cycles, no mem_req -> freeze_if, freeze_id and bubble_id_exe are 1 for exactly those 2 cycles; stall_cycles=2.
REQ-039 branch_taken=1 and hazard_detected=1 in the same cycle -> flush_if_id=flush_id_exe=1, bubble_id_exe=0; flush_events=1.
REQ-040 mem_r_en=1 with sram_ready pulsing on the 3rd cycle -> freeze_all=1 for 2 cycles and 0 in the 3rd; stall_cycles=2.
REQ-041 MEM_TIMEOUT=4, mem_w_en held at 1, sram_ready=0 -> freeze_all=1 for cycles 1-4 and 0 in cycle 5; mem_error=1 from cycle 6.
REQ-042 branch_taken=1 arriving during a 3-cycle memory freeze -> no flush while frozen; flush_if_id=1 in the release cycle.
REQ-043 rst=1 during MEM_WAIT with stall_cycles=0xFFFF -> all outputs 0 and counters 0 on the next cycle; a new mem_req re-enters MEM_WAIT normally.

Source files
------------

// File: rtl/pipeline_control_unit_if.sv
// Pipeline control bundle.
//   master : hazard/branch/memory status toward the control unit (pipeline side)
//   slave  : the control unit; returns stall/flush/freeze controls and counters
interface pipeline_control_unit_if #(
  parameter int CNT_W = 16
);
  // status from the pipeline
  logic             hazard_detected;
  logic             branch_taken;
  logic             mem_r_en;
  logic             mem_w_en;
  logic             sram_ready;
  // controls back to the pipeline
  logic             freeze_if;
  logic             freeze_id;
  logic             bubble_id_exe;
  logic             flush_if_id;
  logic             flush_id_exe;
  logic             freeze_all;
  logic             mem_error;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_events;

  modport master (
    output hazard_detected, branch_taken, mem_r_en, mem_w_en, sram_ready,
    input  freeze_if, freeze_id, bubble_id_exe, flush_if_id, flush_id_exe,
           freeze_all, mem_error, stall_cycles, flush_events
  );

  modport slave (
    input  hazard_detected, branch_taken, mem_r_en, mem_w_en, sram_ready,
    output freeze_if, freeze_id, bubble_id_exe, flush_if_id, flush_id_exe,
           freeze_all, mem_error, stall_cycles, flush_events
  );
endinterface

// File: rtl/pipeline_control_unit.sv
// Pipeline control unit: arbitrates memory freezes, branch flushes and RAW
// hazard stalls for a 5-stage pipeline, bounds memory waits with a timeout,
// and keeps saturating stall/flush counters.
//   clk  : single clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : pipeline_control_unit_if.slave (status in, controls/counters out)
// Control outputs are combinational so they act in the same cycle as the
// inputs that cause them.
module pipeline_control_unit #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  pipeline_control_unit_if.slave  bus
);

  localparam logic [0:0]       RUN      = 1'b0;
  localparam logic [0:0]       MEM_WAIT = 1'b1;
  localparam logic [9:0]       TIMEOUT  = 10'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [0:0]       state_q, state_d;
  logic [9:0]       wait_cnt_q, wait_cnt_d;
  logic             mem_error_q, mem_error_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0] flush_events_q, flush_events_d;

  logic mem_req;
  logic mem_freeze;
  logic freeze_all, do_flush, do_stall;

  assign mem_req = bus.mem_r_en | bus.mem_w_en;

  // Memory wait FSM. wait_cnt counts cycles already spent frozen on the
  // current request, so freeze_all drops once it reaches MEM_TIMEOUT.
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    mem_error_d = mem_error_q;
    mem_freeze  = 1'b0;
    case (state_q)
      RUN: begin
        if (mem_req && !bus.sram_ready) begin
          mem_freeze = 1'b1;
          wait_cnt_d = 10'd1;
          state_d    = MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        if (bus.sram_ready) begin
          wait_cnt_d = '0;
          state_d    = RUN;
        end else if (wait_cnt_q < TIMEOUT) begin
          mem_freeze = 1'b1;
          wait_cnt_d = wait_cnt_q + 10'd1;
        end else begin
          // abort: release the pipeline and flag the error; it never
          // changes sequencing afterwards
          mem_error_d = 1'b1;
          wait_cnt_d  = '0;
          state_d     = RUN;
        end
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  // Priority: memory freeze > branch flush > hazard stall. While frozen the
  // pipeline holds branch/hazard stable, so they are acted on at release.
  always_comb begin
    freeze_all = !rst && mem_freeze;
    do_flush   = !rst && !mem_freeze && bus.branch_taken;
    do_stall   = !rst && !mem_freeze && !bus.branch_taken && bus.hazard_detected;
  end

  assign bus.freeze_all    = freeze_all;
  assign bus.flush_if_id   = do_flush;
  assign bus.flush_id_exe  = do_flush;
  assign bus.freeze_if     = do_stall;
  assign bus.freeze_id     = do_stall;
  assign bus.bubble_id_exe = do_stall;
  assign bus.mem_error     = mem_error_q;
  assign bus.stall_cycles  = stall_cycles_q;
  assign bus.flush_events  = flush_events_q;

  // Saturating performance counters.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_events_d = flush_events_q;
    if ((freeze_all || do_stall) && stall_cycles_q != CNT_MAX)
      stall_cycles_d = stall_cycles_q + 1'b1;
    if (do_flush && flush_events_q != CNT_MAX)
      flush_events_d = flush_events_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= RUN;
      wait_cnt_q     <= '0;
      mem_error_q    <= 1'b0;
      stall_cycles_q <= '0;
      flush_events_q <= '0;
    end else begin
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      mem_error_q    <= mem_error_d;
      stall_cycles_q <= stall_cycles_d;
      flush_events_q <= flush_events_d;
    end
  end

endmodule

// File: tb/tb_pipeline_control_unit.sv
// Directed, table-driven bench for pipeline_control_unit (MEM_TIMEOUT=4).
module tb_pipeline_control_unit;
  localparam int CNT_W = 16;
  localparam int TMO   = 4;

  // control vector order: {freeze_if, freeze_id, bubble, flush_if_id, flush_id_exe, freeze_all}
  localparam logic [5:0] C_NONE  = 6'b000000;
  localparam logic [5:0] C_STALL = 6'b111000;
  localparam logic [5:0] C_FLUSH = 6'b000110;
  localparam logic [5:0] C_FA    = 6'b000001;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipeline_control_unit_if #(.CNT_W(CNT_W)) bus();
  pipeline_control_unit #(.MEM_TIMEOUT(TMO), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  typedef struct {
    logic             r, hz, br, rd, wr, rdy;
    logic [5:0]       ctl;
    logic [CNT_W-1:0] stall, flush;
    logic             err;
  } vec_t;

  vec_t vecs[28];
  int errors = 0;
  int checks = 0;

  function automatic vec_t mk(logic r, logic hz, logic br, logic rd, logic wr, logic rdy,
                              logic [5:0] ctl, int stall, int flush, logic err);
    vec_t v;
    v.r = r; v.hz = hz; v.br = br; v.rd = rd; v.wr = wr; v.rdy = rdy;
    v.ctl = ctl; v.stall = CNT_W'(stall); v.flush = CNT_W'(flush); v.err = err;
    return v;
  endfunction

  task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step=%0d got=%0h expected=%0h", name, idx, act, exp);
    end
  endtask

  function automatic logic [5:0] ctl_now();
    return {bus.freeze_if, bus.freeze_id, bus.bubble_id_exe,
            bus.flush_if_id, bus.flush_id_exe, bus.freeze_all};
  endfunction

  task automatic drive(logic r, logic hz, logic br, logic rd, logic wr, logic rdy);
    @(negedge clk);
    rst = r;
    bus.hazard_detected = hz;
    bus.branch_taken    = br;
    bus.mem_r_en        = rd;
    bus.mem_w_en        = wr;
    bus.sram_ready      = rdy;
    #1;
  endtask

  // Apply one cycle: check combinational controls before the edge, then
  // counters and the sticky error flag just after it.
  task automatic step(vec_t v, int idx);
    drive(v.r, v.hz, v.br, v.rd, v.wr, v.rdy);
    chk("ctl", idx, 32'(ctl_now()), 32'(v.ctl));
    @(posedge clk);
    #1;
    chk("stall_cycles", idx, 32'(bus.stall_cycles), 32'(v.stall));
    chk("flush_events", idx, 32'(bus.flush_events), 32'(v.flush));
    chk("mem_error", idx, 32'(bus.mem_error), 32'(v.err));
  endtask

  initial begin
    rst = 1'b1;
    bus.hazard_detected = 1'b0; bus.branch_taken = 1'b0;
    bus.mem_r_en = 1'b0; bus.mem_w_en = 1'b0; bus.sram_ready = 1'b0;

    //            r  hz br rd wr rdy  ctl      stall flush err
    vecs[0]  = mk(1, 1, 1, 1, 0, 0,  C_NONE,  0,  0, 0); // reset gates controls
    vecs[1]  = mk(0, 0, 0, 0, 0, 0,  C_NONE,  0,  0, 0);
    vecs[2]  = mk(0, 1, 0, 0, 0, 0,  C_STALL, 1,  0, 0); // 2-cycle hazard
    vecs[3]  = mk(0, 1, 0, 0, 0, 0,  C_STALL, 2,  0, 0);
    vecs[4]  = mk(0, 0, 0, 0, 0, 0,  C_NONE,  2,  0, 0);
    vecs[5]  = mk(0, 1, 1, 0, 0, 0,  C_FLUSH, 2,  1, 0); // branch beats hazard
    vecs[6]  = mk(0, 0, 1, 0, 0, 0,  C_FLUSH, 2,  2, 0);
    vecs[7]  = mk(0, 0, 0, 1, 0, 1,  C_NONE,  2,  2, 0); // zero-wait load
    vecs[8]  = mk(0, 0, 0, 1, 0, 0,  C_FA,    3,  2, 0); // ready on 3rd cycle
    vecs[9]  = mk(0, 0, 0, 1, 0, 0,  C_FA,    4,  2, 0);
    vecs[10] = mk(0, 0, 0, 1, 0, 1,  C_NONE,  4,  2, 0);
    vecs[11] = mk(0, 0, 1, 1, 0, 0,  C_FA,    5,  2, 0); // branch during freeze
    vecs[12] = mk(0, 0, 1, 1, 0, 0,  C_FA,    6,  2, 0);
    vecs[13] = mk(0, 1, 1, 1, 0, 0,  C_FA,    7,  2, 0);
    vecs[14] = mk(0, 1, 1, 1, 0, 1,  C_FLUSH, 7,  3, 0); // flush at release
    vecs[15] = mk(0, 0, 0, 0, 0, 0,  C_NONE,  7,  3, 0);
    vecs[16] = mk(0, 0, 0, 0, 1, 0,  C_FA,    8,  3, 0); // timeout: 4 frozen
    vecs[17] = mk(0, 0, 0, 0, 1, 0,  C_FA,    9,  3, 0);
    vecs[18] = mk(0, 0, 0, 0, 1, 0,  C_FA,    10, 3, 0);
    vecs[19] = mk(0, 0, 0, 0, 1, 0,  C_FA,    11, 3, 0);
    vecs[20] = mk(0, 0, 0, 0, 1, 0,  C_NONE,  11, 3, 1); // abort cycle
    vecs[21] = mk(0, 0, 0, 0, 0, 0,  C_NONE,  11, 3, 1);
    vecs[22] = mk(0, 0, 0, 0, 1, 1,  C_NONE,  11, 3, 1); // error is sticky, no effect
    vecs[23] = mk(0, 1, 0, 0, 1, 0,  C_FA,    12, 3, 1); // freeze beats hazard
    vecs[24] = mk(1, 0, 0, 0, 1, 0,  C_NONE,  0,  0, 0); // reset in MEM_WAIT
    vecs[25] = mk(0, 0, 0, 0, 1, 0,  C_FA,    1,  0, 0); // back in RUN
    vecs[26] = mk(0, 0, 0, 0, 1, 1,  C_NONE,  1,  0, 0);
    vecs[27] = mk(0, 0, 0, 0, 0, 0,  C_NONE,  1,  0, 0);

    for (int i = 0; i < 28; i++) step(vecs[i], i);

    // Saturation, then reset during MEM_WAIT with a full counter.
    for (int i = 0; i < 65540; i++) drive(0, 1, 0, 0, 0, 0);
    chk("sat_bubble", 100, 32'(ctl_now()), 32'(C_STALL));
    @(posedge clk); #1;
    chk("sat_stall", 100, 32'(bus.stall_cycles), 32'h0000_FFFF);
    step(mk(0, 0, 0, 0, 1, 0, C_FA,   'hFFFF, 0, 0), 101); // enter MEM_WAIT, held at max
    step(mk(1, 0, 0, 0, 1, 0, C_NONE, 0,      0, 0), 102); // reset abandons request
    step(mk(0, 0, 0, 0, 1, 0, C_FA,   1,      0, 0), 103); // re-enter MEM_WAIT
    step(mk(0, 0, 0, 0, 1, 0, C_FA,   2,      0, 0), 104);
    step(mk(0, 0, 0, 0, 1, 1, C_NONE, 2,      0, 0), 105);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
